// File: rtl/btn_pkg.sv
// Shared encodings for the button event arbiter and its repeat timers.
// Timer states follow the button lifecycle: released, waiting for first repeat, repeating.
// The output register is a one-entry slot: empty or holding a presented event.
package btn_pkg;

  typedef enum logic [1:0] {
    RT_RELEASED = 2'b00,
    RT_DELAY    = 2'b01,
    RT_REPEAT   = 2'b10
  } rpt_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Valid/ready event stream from the arbiter to the game logic.
// The master presents EVT_ID/EVT_REP with EVT_VALID; the slave accepts with EVT_READY.
// Payload is held stable by the master while EVT_VALID=1 and EVT_READY=0.
interface btn_event_arbiter_if #(
  parameter int IDW = 2
);
  logic           EVT_VALID;
  logic           EVT_READY;
  logic [IDW-1:0] EVT_ID;
  logic           EVT_REP;

  modport master (
    output EVT_VALID,
    output EVT_ID,
    output EVT_REP,
    input  EVT_READY
  );

  modport slave (
    input  EVT_VALID,
    input  EVT_ID,
    input  EVT_REP,
    output EVT_READY
  );
endinterface

// File: rtl/btn_repeat_timer.sv
// Per-button hold-to-repeat timer: fires REPEAT_DLY cycles after a press, then every REPEAT_PER.
// FIRE is asserted in the cycle whose closing edge is the fire edge, so the pending bit sets on it.
// A press restarts the delay; a release (level low) cancels everything and beats a fire.
module btn_repeat_timer
  import btn_pkg::*;
#(
  parameter int            CW         = 24,
  parameter logic [CW-1:0] REPEAT_DLY = 24'd5_000_000,
  parameter logic [CW-1:0] REPEAT_PER = 24'd1_250_000
) (
  input  logic CLK,
  input  logic ACLR,
  input  logic BTN_PULSE,
  input  logic BTN_LEVEL,
  output logic FIRE
);

  rpt_state_t    state;
  logic [CW-1:0] count;

  // A fire happens when an armed timer has run out and the button is still held.
  assign FIRE = (state != RT_RELEASED) && BTN_LEVEL && (count == '0);

  // Timer state and countdown; press restarts, release cancels, expiry reloads the period.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      state <= RT_RELEASED;
      count <= '0;
    end else if (BTN_PULSE) begin
      state <= RT_DELAY;
      count <= REPEAT_DLY - 1'b1;
    end else if (!BTN_LEVEL) begin
      state <= RT_RELEASED;
      count <= '0;
    end else if (state != RT_RELEASED) begin
      if (count == '0) begin
        state <= RT_REPEAT;
        count <= REPEAT_PER - 1'b1;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Queues button presses and auto-repeats per button, round-robin serialises them to one stream.
// Latency: press pulse at edge k -> EVT_VALID after edge k+1 when the output slot is empty.
// Backpressure: slot holds while EVT_READY=0; repeated sets on a queued button raise sticky OVF.
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int            N_BTN      = 4,
  parameter int            IDW        = 2,
  parameter int            CW         = 24,
  parameter logic [CW-1:0] REPEAT_DLY = 24'd5_000_000,
  parameter logic [CW-1:0] REPEAT_PER = 24'd1_250_000
) (
  input  logic                 CLK,
  input  logic                 ACLR,
  input  logic [N_BTN-1:0]     BTN_PULSE,
  input  logic [N_BTN-1:0]     BTN_LEVEL,
  input  logic                 CLR_OVF,
  btn_event_arbiter_if.master  evt,
  output logic [N_BTN-1:0]     OVF
);

  logic [N_BTN-1:0] fire;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] rep;
  logic [N_BTN-1:0] ovf_q;
  logic [N_BTN-1:0] set_vec;
  logic [N_BTN-1:0] drop_vec;
  logic [N_BTN-1:0] gnt_vec;
  logic [N_BTN-1:0] rep_n;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_n;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             grant;
  int               scan_idx;

  out_state_t       state;
  logic             valid_q;
  logic [IDW-1:0]   id_q;
  logic             rep_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_timer
    btn_repeat_timer #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER),
      .CW         (CW)
    ) u_timer (
      .CLK       (CLK),
      .ACLR      (ACLR),
      .BTN_PULSE (BTN_PULSE[g]),
      .BTN_LEVEL (BTN_LEVEL[g]),
      .FIRE      (fire[g])
    );
  end

  // Round-robin search: first pending index at or above ptr, wrapping modulo N_BTN.
  // Scanning from the farthest offset down lets the nearest match overwrite the others.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int off = N_BTN - 1; off >= 0; off--) begin
      scan_idx = int'(ptr) + off;
      if (scan_idx >= N_BTN) scan_idx = scan_idx - N_BTN;
      if (pend[scan_idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx[IDW-1:0];
      end
    end
  end

  // A grant needs a free slot this cycle: empty, or the presented event is being taken.
  assign grant = gnt_any && ((state == OUT_EMPTY) || evt.EVT_READY);

  // Explicit wrap so non-power-of-two button counts never point past the last button.
  assign ptr_n = (gnt_idx == IDW'(N_BTN - 1)) ? '0 : gnt_idx + IDW'(1);

  // One-hot grant plus the per-button set/drop/source-bit next values.
  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      gnt_vec[i] = grant && (gnt_idx == IDW'(i));
    end
    set_vec  = BTN_PULSE | fire;
    drop_vec = set_vec & pend & ~gnt_vec;
    // Pulse forces a fresh press; a repeat marks rep only if it is not merely a drop.
    rep_n    = (rep & ~BTN_PULSE) | (fire & ~BTN_PULSE & ~drop_vec);
  end

  // Pending queue, source bits and sticky overflow; a set beats both grant-clear and CLR_OVF.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      pend  <= '0;
      rep   <= '0;
      ovf_q <= '0;
    end else begin
      pend  <= set_vec | (pend & ~gnt_vec);
      rep   <= rep_n;
      ovf_q <= drop_vec | (CLR_OVF ? '0 : ovf_q);
    end
  end

  // Round-robin pointer advances past each grantee.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= ptr_n;
    end
  end

  // Output slot FSM with registered payload; reloads in place for back-to-back events.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      state   <= OUT_EMPTY;
      valid_q <= 1'b0;
      id_q    <= '0;
      rep_q   <= 1'b0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (grant) begin
            state   <= OUT_FULL;
            valid_q <= 1'b1;
            id_q    <= gnt_idx;
            rep_q   <= rep[gnt_idx];
          end
        end
        OUT_FULL: begin
          if (evt.EVT_READY) begin
            if (grant) begin
              id_q  <= gnt_idx;
              rep_q <= rep[gnt_idx];
            end else begin
              state   <= OUT_EMPTY;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= OUT_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt.EVT_VALID = valid_q;
  assign evt.EVT_ID    = id_q;
  assign evt.EVT_REP   = rep_q;
  assign OVF           = ovf_q;

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects debounced pushbutton pulses and held levels from N player buttons, adds hold-to-repeat, and serializes them through a round-robin arbiter into one valid/ready event stream for the game logic. It sits between the per-button debouncers and the game state machine. Presses are never lost while an event for the same button is already queued; drops are flagged.

## Interface
- N_BTN, 4: number of buttons, 2..8
- IDW, 2: event ID width, clog2(N_BTN)
- REPEAT_DLY, 24'd5_000_000: hold cycles before the first repeat, ≥2
- REPEAT_PER, 24'd1_250_000: cycles between subsequent repeats, ≥2
- CW, 24: repeat counter width
- CLK  in  1  system clock, rising edge
- ACLR  in  1  asynchronous reset, active-high
- BTN_PULSE  in  N_BTN  one-cycle debounced press pulse per button
- BTN_LEVEL  in  N_BTN  debounced held level per button
- CLR_OVF  in  1  synchronous clear of OVF
- EVT_READY  in  1  consumer accepts the event this cycle
- EVT_VALID  out  1  event present
- EVT_ID  out  IDW  button index of the event
- EVT_REP  out  1  1 = auto-repeat event, 0 = fresh press
- OVF  out  N_BTN  sticky per-button drop flags

## Operation
- Per-button pending bit pend[i] and source bit rep[i].
- Set sources:
  - BTN_PULSE[i] sets pend[i] with rep[i]=0.
  - A repeat fire sets pend[i] with rep[i]=1.
  - If both occur in the same cycle, the pulse wins.
- Clear: pend[i] clears when button i is granted. Set beats clear in the same cycle, so a new event is queued.
- Drop: a set arriving while pend[i]=1 and i is not granted that cycle sets OVF[i]. A pulse overwrites rep[i] to 0; a repeat leaves rep[i] unchanged. OVF[i] clears only on CLR_OVF; a set on the same cycle as CLR_OVF wins.
- Repeat timer per button, states RELEASED / DELAY / REPEAT:
  - RELEASED, on BTN_PULSE[i]: load count = REPEAT_DLY-1, go to DELAY.
  - DELAY or REPEAT, with BTN_LEVEL[i]=1: if count=0, fire, load count = REPEAT_PER-1, go to REPEAT. Otherwise decrement.
  - Any state, with BTN_LEVEL[i]=0: go to RELEASED, count=0. Release beats fire.
  - A BTN_PULSE[i] in DELAY or REPEAT restarts DELAY.
- Arbiter: round-robin pointer ptr (IDW bits).
  - Grant eligibility: the output slot is empty, or EVT_VALID=1 and EVT_READY=1.
  - The grantee is the first pend index at or above ptr, wrapping modulo N_BTN.
  - On grant, ptr becomes grantee+1. It wraps to 0 after N_BTN-1, including when N_BTN is not a power of two.
- Output register FSM, states EMPTY / FULL:
  - EMPTY: a grant loads EVT_ID/EVT_REP, go to FULL.
  - FULL: EVT_READY without a grant goes to EMPTY. EVT_READY with a grant reloads and stays in FULL (back-to-back).
- Handshake:
  - EVT_ID and EVT_REP stay stable while EVT_VALID=1 and EVT_READY=0.
  - EVT_READY is ignored while EVT_VALID=0.

## Timing
- Reset values: EVT_VALID=0, EVT_ID=0, EVT_REP=0, OVF=0, pend=0, rep=0, ptr=0, all timers RELEASED with count=0.
- ACLR asserted mid-operation discards queued and presented events immediately; no event is emitted after release.
- Press latency: BTN_PULSE sampled at edge k, pend set after k, EVT_VALID=1 after edge k+1 (2 cycles) when the slot is empty.
- Throughput: one event per cycle while EVT_READY is held high.
- First repeat fires REPEAT_DLY cycles after the press edge; later repeats every REPEAT_PER cycles.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package btn_pkg:
  - Repeat-timer state encodings (RELEASED=2'b00, DELAY=2'b01, REPEAT=2'b10).
  - Output FSM encodings (EMPTY=1'b0, FULL=1'b1).
- Sub-module btn_repeat_timer, one instance per button (generate loop):
  - Ports: CLK, ACLR, BTN_PULSE, BTN_LEVEL, FIRE.
  - Parameters: REPEAT_DLY, REPEAT_PER, CW.
- Pending logic, arbiter and output register live in the top.

## Test plan
All scenarios use REPEAT_DLY=8 and REPEAT_PER=4.
- Single press: pulse on btn 2 at edge 10, EVT_READY=1 → EVT_VALID=1 for one cycle after edge 11, EVT_ID=2, EVT_REP=0.
- Simultaneous presses: pulses on btns 0, 1 and 3 at one edge, ptr=0, EVT_READY=1 → IDs 0, 1, 3 on consecutive cycles; ptr ends at 0.
- Backpressure and drop: EVT_READY=0, btn 1 presented; pulse btn 1 twice more → EVT_ID held at 1. OVF[1]=1 after the second extra pulse, and exactly one more btn-1 event is delivered after EVT_READY rises.
- Auto-repeat: hold btn 0 for 20 cycles after the press → 1 press event plus repeat events (EVT_REP=1) fired at +8, +12 and +16 cycles. Releasing at +15 suppresses the +16 repeat.
- Reset mid-operation: assert ACLR while EVT_VALID=1 and pend=4'b1010 → all outputs reset immediately; no event after release until a new pulse.
- Same-cycle grant and re-press: grant btn 3 while a new btn-3 pulse arrives → second btn-3 event delivered, OVF[3]=0.
